// File: rtl/exmem_stage.sv
// exmem_stage: MIPS execute stage with EX/MEM pipeline register and a
// 32-step shift-add multiplier feeding HI/LO.
module exmem_stage #(
    parameter int MULT_CYCLES = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] signExtendedInstruction,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] PcP4,
    input  logic [4:0]  RegDst0,
    input  logic [4:0]  RegDst1,
    input  logic        RegDstSelect,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic        MemWrite,
    input  logic        AluSrcSelect,
    input  logic        RegWrite,
    input  logic [1:0]  ALUOp,
    input  logic [5:0]  opCode,
    output logic        stall,
    output logic [31:0] EXMEMaluResult,
    output logic [31:0] EXMEMwriteData,
    output logic [4:0]  EXMEMwriteReg,
    output logic [31:0] EXMEMbranchTarget,
    output logic        EXMEMbranchTaken,
    output logic        EXMEMMemRead,
    output logic        EXMEMMemToReg,
    output logic        EXMEMMemWrite,
    output logic        EXMEMRegWrite,
    output logic        mulBusy
);

    localparam int CW = $clog2(MULT_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_next;
    logic [5:0]     funct;
    logic [4:0]     shamt;
    logic [31:0]    imm_zx, op_b;
    logic           r_type, is_mul, is_hilo, signed_mul, start, last_step;
    logic [31:0]    alu_result;
    logic           alu_known;
    logic [31:0]    hi, lo;
    logic [63:0]    mcand, acc, acc_step;
    logic [31:0]    mplier, mag_a, mag_b;
    logic           neg;
    logic [CW-1:0]  count;
    logic [31:0]    branch_target;
    logic           branch_taken;

    assign funct      = signExtendedInstruction[5:0];
    assign shamt      = signExtendedInstruction[10:6];
    assign imm_zx     = {16'h0, signExtendedInstruction[15:0]};
    assign op_b       = AluSrcSelect ? signExtendedInstruction : readData2;
    assign r_type     = ALUOp == 2'b10;
    assign is_mul     = r_type & (funct == 6'h18 | funct == 6'h19);
    assign is_hilo    = r_type & (funct == 6'h10 | funct == 6'h12);
    assign signed_mul = funct == 6'h18;
    assign stall      = mulBusy & (is_mul | is_hilo);
    // A mult only reaches here unstalled when the multiplier is idle.
    assign start      = is_mul & ~mulBusy;

    always_comb begin
        alu_result = 32'h0;
        alu_known  = 1'b1;
        case (ALUOp)
            2'b00: alu_result = readData1 + op_b;
            2'b01: alu_result = readData1 - op_b;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: alu_result = readData1 + op_b;
                    6'h22, 6'h23: alu_result = readData1 - op_b;
                    6'h24:        alu_result = readData1 & op_b;
                    6'h25:        alu_result = readData1 | op_b;
                    6'h26:        alu_result = readData1 ^ op_b;
                    6'h27:        alu_result = ~(readData1 | op_b);
                    6'h2A:        alu_result = {31'h0, $signed(readData1) < $signed(op_b)};
                    6'h2B:        alu_result = {31'h0, readData1 < op_b};
                    6'h00:        alu_result = readData2 << shamt;
                    6'h02:        alu_result = readData2 >> shamt;
                    6'h03:        alu_result = $signed(readData2) >>> shamt;
                    6'h10:        alu_result = hi;
                    6'h12:        alu_result = lo;
                    6'h18, 6'h19: alu_result = 32'h0;
                    default:      alu_known  = 1'b0;
                endcase
            end
            default: begin
                case (opCode)
                    6'h08, 6'h09: alu_result = readData1 + op_b;
                    6'h0A:        alu_result = {31'h0, $signed(readData1) < $signed(op_b)};
                    6'h0B:        alu_result = {31'h0, readData1 < op_b};
                    6'h0C:        alu_result = readData1 & imm_zx;
                    6'h0D:        alu_result = readData1 | imm_zx;
                    6'h0E:        alu_result = readData1 ^ imm_zx;
                    6'h0F:        alu_result = {signExtendedInstruction[15:0], 16'h0};
                    default:      alu_known  = 1'b0;
                endcase
            end
        endcase
    end

    assign branch_target = PcP4 + {signExtendedInstruction[29:0], 2'b00};
    assign branch_taken  = Branch & ((opCode == 6'h04 & readData1 == readData2) |
                                     (opCode == 6'h05 & readData1 != readData2));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (start ? RUN : IDLE) : (last_step ? IDLE : RUN);
    end

    always_comb begin
        mulBusy = state == RUN;
    end

    // Signed multiply runs on magnitudes; the sign is reapplied on the final write.
    assign mag_a     = (signed_mul & readData1[31]) ? -readData1 : readData1;
    assign mag_b     = (signed_mul & readData2[31]) ? -readData2 : readData2;
    assign acc_step  = acc + (mplier[0] ? mcand : 64'h0);
    assign last_step = count == CW'(MULT_CYCLES - 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mcand  <= 64'h0;
            mplier <= 32'h0;
            acc    <= 64'h0;
            neg    <= 1'b0;
            count  <= '0;
            hi     <= 32'h0;
            lo     <= 32'h0;
        end else if (state == IDLE) begin
            if (start) begin
                mcand  <= {32'h0, mag_a};
                mplier <= mag_b;
                acc    <= 64'h0;
                neg    <= signed_mul & (readData1[31] ^ readData2[31]);
                count  <= '0;
            end
        end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= last_step ? '0 : count + 1'b1;
            if (last_step) {hi, lo} <= neg ? -acc_step : acc_step;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            EXMEMaluResult    <= 32'h0;
            EXMEMwriteData    <= 32'h0;
            EXMEMwriteReg     <= 5'h0;
            EXMEMbranchTarget <= 32'h0;
            EXMEMbranchTaken  <= 1'b0;
            EXMEMMemRead      <= 1'b0;
            EXMEMMemToReg     <= 1'b0;
            EXMEMMemWrite     <= 1'b0;
            EXMEMRegWrite     <= 1'b0;
        end else begin
            EXMEMaluResult    <= stall ? 32'h0 : alu_result;
            EXMEMwriteData    <= stall ? 32'h0 : readData2;
            EXMEMwriteReg     <= stall ? 5'h0 : (RegDstSelect ? RegDst1 : RegDst0);
            EXMEMbranchTarget <= stall ? 32'h0 : branch_target;
            EXMEMbranchTaken  <= ~stall & branch_taken;
            EXMEMMemRead      <= ~stall & MemRead;
            EXMEMMemToReg     <= ~stall & MemToReg;
            EXMEMMemWrite     <= ~stall & MemWrite;
            EXMEMRegWrite     <= ~stall & RegWrite & alu_known & ~is_mul;
        end
    end

endmodule

// File: doc/exmem_stage.md
# exmem_stage

Execute stage of the 5-stage MIPS pipeline, with the EX/MEM pipeline register. It consumes the registered outputs of the ID/EX register and performs the following work:
- decodes the ALU operation;
- computes the ALU result, branch target and branch decision;
- runs a 32-cycle sequential multiplier into HI/LO;
- registers everything the MEM and WB stages need.

While the multiplier is busy and the instruction in EX needs it, the block raises a stall so the front end holds.

## Interface
Parameters:
- MULT_CYCLES, 32, iterations of the shift-add multiplier. Fixed at 32; the parameter is provided for the bench only.

Ports:
- clock, input, 1, the single pipeline clock; all state is updated on the rising edge.
- resetn, input, 1, asynchronous, active-low reset.
- signExtendedInstruction, input, 32, sign-extended imm16 from ID/EX. Bits [5:0] are funct and bits [10:6] are shamt.
- readData1 / readData2, input, 32 each, rs and rt operands.
- PcP4, input, 32, PC+4 of the instruction in EX.
- RegDst0 / RegDst1, input, 5 each, rt and rd.
- RegDstSelect, Branch, MemRead, MemToReg, MemWrite, AluSrcSelect, RegWrite, input, 1 each, control signals from ID/EX.
- ALUOp, input, 2, ALU operation class.
- opCode, input, 6, instruction opcode.
- stall, output, 1, combinational. When high, upstream must hold PC, IF/ID and ID/EX.
- EXMEMaluResult, output, 32.
- EXMEMwriteData, output, 32, registered readData2.
- EXMEMwriteReg, output, 5.
- EXMEMbranchTarget, output, 32.
- EXMEMbranchTaken, output, 1.
- EXMEMMemRead, EXMEMMemToReg, EXMEMMemWrite, EXMEMRegWrite, output, 1 each.
- mulBusy, output, 1, multiplier running; debug only.

## Operation
Operand and destination selection:
- Operand B = AluSrcSelect ? signExtendedInstruction : readData2.
- Write register = RegDstSelect ? RegDst1 : RegDst0.

ALU operation by ALUOp:
- ALUOp 00: add (lw/sw address).
- ALUOp 01: subtract (branch compare).
- ALUOp 10: R-type, selected by funct:
  - 0x20/0x21 add, 0x22/0x23 sub.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra, applied to readData2 with shift amount shamt.
  - 0x10 mfhi and 0x12 mflo: result = HI or LO.
  - 0x18 mult and 0x19 multu: start the multiplier.
  - Unknown funct: result 0 and RegWrite forced to 0.
- ALUOp 11: immediate, selected by opCode:
  - 0x08/0x09 add, 0x0A slti, 0x0B sltiu.
  - 0x0C andi, 0x0D ori, 0x0E xori: use the zero-extended imm[15:0].
  - 0x0F lui: result = {imm[15:0], 16'h0}.
  - Unknown opcode: result 0 and RegWrite forced to 0.
- All arithmetic is 32-bit and wraps. No overflow traps.

Branch:
- Target = PcP4 + (signExtendedInstruction << 2), modulo 2^32.
- Taken = Branch & ((opCode==0x04 & rs==rt) | (opCode==0x05 & rs!=rt)).

Multiplier (states IDLE and RUN):
- IDLE→RUN when a mult/multu is in EX and stall is 0. Operands are latched; for mult the signs are recorded and magnitudes are used.
- RUN: one shift-add step per cycle into a 64-bit accumulator.
- After MULT_CYCLES steps: RUN→IDLE and {HI,LO} is written. For mult, the product is negated when the operand signs differ.
- The mult/multu instruction itself writes no GPR; it enters EX/MEM with RegWrite=0.

Stall rule:
- stall = mulBusy & (instruction in EX is mult, multu, mfhi or mflo).
- While stall=1, the EX/MEM register loads a bubble: all four control outputs are 0 and the data fields are don't-care (implemented as 0).
- Non-mult instructions proceed normally while the multiplier runs. They do not read HI/LO.

## Timing
- Reset (resetn low, asynchronous): all EXMEM* outputs are 0, HI = LO = 0, state IDLE, mulBusy = 0, step counter 0.
- A reset during RUN aborts the multiply. HI/LO stay 0 and no partial result is ever written.
- ALU, branch and register results appear on the EXMEM* outputs 1 cycle after the instruction is in EX (registered at the next edge).
- Multiply start: mult is in EX in cycle N; the FSM captures at edge N.
- mulBusy is high in cycles N+1 through N+32.
- HI/LO are updated at edge N+32, and mulBusy is low from cycle N+33.
- An mfhi in EX during any of cycles N+1..N+32 holds stall=1. In cycle N+33 it reads the new HI and registers it at that cycle's edge.
- A back-to-back second mult in EX during RUN stalls. It starts on the first cycle with mulBusy=0 (reading LO then is also legal).
- stall depends only on the current inputs and registered state, with no loop through the outputs.

## Test plan
- Reset: hold resetn=0 with random inputs. Expect all outputs 0 and stall=0. Release mid-cycle; the first edge registers normally.
- R-type add: readData1=7, readData2=0xFFFFFFFC, ALUOp=10, funct=0x20, RegDstSelect=1, RegDst1=9. Next cycle: aluResult=3, writeReg=9, RegWrite=1.
- beq: rs=rt=5, imm=0xFFFFFFFF, PcP4=0x100, Branch=1, opCode=0x04. Expect branchTaken=1 and branchTarget=0xFC. With rs≠rt, branchTaken=0.
- Signed mult: 0xFFFFFFFD × 6, then mflo immediately behind it. Expect stall high for 32 cycles and EX/MEM bubbles. mflo then yields 0xFFFFFFEE; mfhi yields 0xFFFFFFFF.
- Independent instruction during RUN: ori readData1=0x0F0, imm=0x00F. Expect result 0x0FF with no stall.
- Reset asserted at multiply step 10. Afterwards mfhi/mflo return 0 and mulBusy=0.
